// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register that shows a NOP view when empty and counts stall cycles.
// Defining PIPE_STAGE_SKID_EN adds a skid entry so that in_ready comes from a flop.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'(32'h00000013),
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              r_valid_m;
  logic [DATA_W-1:0] r_data_m;
  logic [CTRL_W-1:0] r_ctrl_m;
  logic [CNT_W-1:0]  r_stall;
  logic              w_acc;
  logic              w_pop;
  assign w_acc = in_valid & in_ready;
  assign w_pop = r_valid_m & out_ready;
`ifdef PIPE_STAGE_SKID_EN
  logic              r_valid_s;
  logic [DATA_W-1:0] r_data_s;
  logic [CTRL_W-1:0] r_ctrl_s;
  assign in_ready = !r_valid_s;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_m <= 1'b0;
      r_valid_s <= 1'b0;
    end else if (flush) begin
      r_valid_m <= 1'b0;
      r_valid_s <= 1'b0;
    end else if (w_pop) begin
      r_valid_m <= r_valid_s | w_acc;
      r_valid_s <= 1'b0;
    end else if (w_acc) begin
      if (r_valid_m) r_valid_s <= 1'b1;
      else r_valid_m <= 1'b1;
    end
  end
  // Payload is don't-care while its valid bit is low, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_pop & r_valid_s) begin
      r_data_m <= r_data_s;
      r_ctrl_m <= r_ctrl_s;
    end else if (w_acc & (w_pop | !r_valid_m)) begin
      r_data_m <= in_data;
      r_ctrl_m <= in_ctrl;
    end
    if (w_acc & r_valid_m & !w_pop) begin
      r_data_s <= in_data;
      r_ctrl_s <= in_ctrl;
    end
  end
`else
  assign in_ready = !r_valid_m | out_ready;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_valid_m <= 1'b0;
    else if (flush) r_valid_m <= 1'b0;
    else if (w_acc) r_valid_m <= 1'b1;
    else if (w_pop) r_valid_m <= 1'b0;
  end
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_data_m <= in_data;
      r_ctrl_m <= in_ctrl;
    end
  end
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_stall <= '0;
    else if (r_valid_m & !out_ready & ~&r_stall) r_stall <= r_stall + CNT_W'(1);
  end
  assign out_valid = r_valid_m;
  assign out_data  = r_valid_m ? r_data_m : RESET_DATA;
  assign out_ctrl  = r_valid_m ? r_ctrl_m : '0;
  assign stall_cnt = r_stall;
endmodule
